// File: rtl/data_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_controller
//  Purpose  : Responder side of the MEM-stage memory handshake. Accepts
//             load/store requests, stalls the pipeline through busy_wait,
//             runs one word-wide access against the backing data memory and
//             returns aligned, sign/zero-extended load data. Flags misaligned
//             requests and memory timeouts.
//  Ports    : clk, reset (async, active-low)
//             read_write[3:0], address[31:0], write_data[31:0]  - request
//             busy_wait, read_data[31:0], misaligned, mem_error - to pipeline
//             mem_read, mem_write, mem_address[29:0], mem_byteen[3:0],
//             mem_writedata[31:0], mem_readdata[31:0], mem_busywait - memory
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  read_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        busy_wait,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        mem_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [29:0] mem_address,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int               CNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  localparam logic [3:0] RW_LB  = 4'b1000;
  localparam logic [3:0] RW_LH  = 4'b1001;
  localparam logic [3:0] RW_LW  = 4'b1010;
  localparam logic [3:0] RW_LBU = 4'b1100;
  localparam logic [3:0] RW_LHU = 4'b1101;
  localparam logic [3:0] RW_SB  = 4'b0100;
  localparam logic [3:0] RW_SH  = 4'b0101;
  localparam logic [3:0] RW_SW  = 4'b0110;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic             req_load, req_store, req_valid, req_misaligned;
  logic [1:0]       req_size;
  logic [3:0]       st_byteen;
  logic [31:0]      st_data;
  logic [3:0]       code_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] count, count_next;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_ext;
  logic             start, complete, abort;

  // --------------------------------------------------------------------------
  // Request decode and store lane placement
  // --------------------------------------------------------------------------
  always_comb begin
    req_load  = 1'b0;
    req_store = 1'b0;
    req_size  = SZ_WORD;
    case (read_write)
      RW_LB, RW_LBU: begin req_load  = 1'b1; req_size = SZ_BYTE; end
      RW_LH, RW_LHU: begin req_load  = 1'b1; req_size = SZ_HALF; end
      RW_LW:         begin req_load  = 1'b1; req_size = SZ_WORD; end
      RW_SB:         begin req_store = 1'b1; req_size = SZ_BYTE; end
      RW_SH:         begin req_store = 1'b1; req_size = SZ_HALF; end
      RW_SW:         begin req_store = 1'b1; req_size = SZ_WORD; end
      default:       ;
    endcase

    req_valid      = req_load | req_store;
    req_misaligned = req_valid &&
                     (((req_size == SZ_HALF) && address[0]) ||
                      ((req_size == SZ_WORD) && (address[1:0] != 2'b00)));

    // Store data is replicated across lanes; the byte enables pick the lane.
    st_byteen = 4'b1111;
    st_data   = write_data;
    case (req_size)
      SZ_BYTE: begin
        st_byteen = 4'b0001 << address[1:0];
        st_data   = {4{write_data[7:0]}};
      end
      SZ_HALF: begin
        st_byteen = address[1] ? 4'b1100 : 4'b0011;
        st_data   = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load lane selection and extension, from the latched request
  // --------------------------------------------------------------------------
  always_comb begin
    rd_byte = mem_readdata[7:0];
    case (lane_q)
      2'd1:    rd_byte = mem_readdata[15:8];
      2'd2:    rd_byte = mem_readdata[23:16];
      2'd3:    rd_byte = mem_readdata[31:24];
      default: ;
    endcase
    rd_half = lane_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];

    // Store codes fall to the default, so store completion yields zero.
    load_ext = 32'h0;
    case (code_q)
      RW_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
      RW_LBU:  load_ext = {24'h0, rd_byte};
      RW_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
      RW_LHU:  load_ext = {16'h0, rd_half};
      RW_LW:   load_ext = mem_readdata;
      default: ;
    endcase
  end

  assign count_next = count + CNT_W'(1);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy_wait  = 1'b0;
    misaligned = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so that a request held during reset stays silent.
        if (reset && req_valid) begin
          if (req_misaligned) begin
            misaligned = 1'b1;
          end else begin
            busy_wait  = 1'b1;
            start      = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        busy_wait = 1'b1;
        // Completion wins over a timeout landing on the same edge.
        if (!mem_busywait) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (count_next == TIMEOUT_VAL) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath and memory-side strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q        <= 4'h0;
      lane_q        <= 2'd0;
      count         <= '0;
      read_data     <= 32'h0;
      mem_error     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= 30'h0;
      mem_byteen    <= 4'h0;
      mem_writedata <= 32'h0;
    end else begin
      mem_error <= 1'b0;

      if (start) begin
        code_q        <= read_write;
        lane_q        <= address[1:0];
        count         <= '0;
        mem_address   <= address[31:2];
        mem_byteen    <= req_store ? st_byteen : 4'h0;
        mem_writedata <= req_store ? st_data : 32'h0;
        mem_read      <= req_load;
        mem_write     <= req_store;
      end

      if (state == ACCESS) count <= count_next;

      if (complete) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        read_data <= load_ext;
      end

      if (abort) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        read_data <= 32'h0;
        mem_error <= 1'b1;
      end

      // Result is only presented for the single DONE cycle.
      if (state == DONE) read_data <= 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_controller
//  Purpose  : Self-checking bench for data_mem_controller. A behavioural
//             byte-addressed memory answers the DUT strobes with a
//             programmable wait count; a reference memory image and rule
//             based load/store functions supply every expected value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_controller;

  localparam int T = 4;

  localparam logic [3:0] LB  = 4'b1000, LH  = 4'b1001, LW = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101;
  localparam logic [3:0] SB  = 4'b0100, SH  = 4'b0101, SW = 4'b0110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  read_write;
  logic [31:0] address, write_data;
  logic        busy_wait, misaligned, mem_error, mem_read, mem_write;
  logic [31:0] read_data, mem_writedata, mem_readdata;
  logic [29:0] mem_address;
  logic [3:0]  mem_byteen;
  logic        mem_busywait;

  int checks = 0;
  int failures = 0;

  data_mem_controller #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .read_write(read_write), .address(address),
    .write_data(write_data), .busy_wait(busy_wait), .read_data(read_data),
    .misaligned(misaligned), .mem_error(mem_error), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_byteen(mem_byteen),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural backing memory ----------------
  logic [31:0] tb_mem  [64];
  logic [31:0] ref_mem [64];
  int wait_target = 0;
  int acc_cycles  = 0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_readdata = tb_mem[mem_address[5:0]];
  assign mem_busywait = (acc_cycles < wait_target);

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
    end else if (mem_write && !mem_busywait) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) tb_mem[mem_address[5:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    if (mem_read || mem_write) acc_cycles <= acc_cycles + 1;
    else                       acc_cycles <= 0;
  end

  // ---------------- reference model ----------------
  function automatic int size_of(logic [3:0] c);
    case (c)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit is_store(logic [3:0] c);
    return (c == SB) || (c == SH) || (c == SW);
  endfunction

  function automatic bit is_misaligned(logic [3:0] c, logic [31:0] a);
    int sz = size_of(c);
    return (sz != 0) && ((int'(a[1:0]) % sz) != 0);
  endfunction

  task automatic ref_init();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
  endtask

  function automatic logic [31:0] model_load(logic [3:0] c, logic [31:0] a);
    longint unsigned w, lane, span;
    int sz = size_of(c);
    w = 64'(ref_mem[a[7:2]]);
    if (sz == 4) return w[31:0];
    span = 64'd1 << (8 * sz);
    lane = (w >> (8 * int'(a[1:0]))) % span;
    if ((c == LB || c == LH) && lane >= span / 2) lane = lane + 64'h1_0000_0000 - span;
    return lane[31:0];
  endfunction

  // Byte b of the bus carries byte (b mod size) of the store data; it is
  // enabled when it falls inside the addressed naturally-aligned unit.
  task automatic exp_lanes(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                           output logic [3:0] be, output logic [31:0] wd);
    int sz = size_of(c);
    int off = int'(a[1:0]);
    be = 4'h0;
    wd = 32'h0;
    for (int b = 0; b < 4; b++) begin
      wd[8*b +: 8] = 8'(d >> (8 * (b % sz)));
      if (b / sz == off / sz) be[b] = 1'b1;
    end
  endtask

  task automatic model_store(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] wd;
    exp_lanes(c, a, d, be, wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // ---------------- transaction driver (records observations) ----------------
  logic        obs_busy0, obs_mis0, obs_err, obs_done_strobe;
  logic        obs_after_busy, obs_after_err, obs_after_mis;
  logic [31:0] obs_rd, obs_after_rd, obs_wdata;
  logic [29:0] obs_addr;
  logic [3:0]  obs_byteen;
  int          obs_stall, obs_rd_cyc, obs_wr_cyc;
  bit          obs_hang;

  task automatic do_req(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wt, input bit idle_after);
    int guard = 0;
    @(negedge clk);
    read_write = code; address = addr; write_data = wdata; wait_target = wt;
    #1;
    obs_busy0 = busy_wait; obs_mis0 = misaligned;
    obs_stall = 0; obs_rd_cyc = 0; obs_wr_cyc = 0; obs_hang = 0;
    obs_addr = '0; obs_byteen = '0; obs_wdata = '0;
    if (mem_read)  obs_rd_cyc++;
    if (mem_write) obs_wr_cyc++;
    while (busy_wait === 1'b1 && guard < 100) begin
      obs_stall++; guard++;
      @(negedge clk); #1;
      if (mem_read)  obs_rd_cyc++;
      if (mem_write) obs_wr_cyc++;
      if (obs_stall == 1) begin
        obs_addr = mem_address; obs_byteen = mem_byteen; obs_wdata = mem_writedata;
      end
    end
    if (guard >= 100) obs_hang = 1;
    obs_rd = read_data; obs_err = mem_error; obs_done_strobe = mem_read | mem_write;
    obs_after_busy = 1'b0; obs_after_err = 1'b0; obs_after_mis = 1'b0; obs_after_rd = 32'h0;
    if (idle_after) begin
      @(negedge clk);
      read_write = 4'b0000;
      #1;
      obs_after_busy = busy_wait; obs_after_err = mem_error;
      obs_after_mis = misaligned; obs_after_rd = read_data;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; read_write = LW; address = 32'h10; write_data = 32'h0; wait_target = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({busy_wait, misaligned, mem_error, mem_read, mem_write} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {busy_wait, misaligned, mem_error, mem_read, mem_write}); end
    checks++; if (read_data !== 32'h0 || mem_address !== 30'h0 || mem_byteen !== 4'h0 || mem_writedata !== 32'h0) begin
      failures++; $display("FAIL reset_data got rd=%h ad=%h be=%h wd=%h exp all zero", read_data, mem_address, mem_byteen, mem_writedata); end
    read_write = 4'b0000;
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy_wait !== 1'b0 || mem_read !== 1'b0) begin
      failures++; $display("FAIL reset_release got busy=%b rd=%b exp 0 0", busy_wait, mem_read); end
  endtask

  task automatic test_lw_basic();
    do_req(SW, 32'h10, 32'hDEAD_BEEF, 0, 1);
    model_store(SW, 32'h10, 32'hDEAD_BEEF);
    do_req(LW, 32'h10, 32'h0, 0, 1);
    checks++; if (obs_busy0 !== 1'b1 || obs_stall !== 2) begin
      failures++; $display("FAIL lw_stall got busy0=%b stall=%0d exp 1 2", obs_busy0, obs_stall); end
    checks++; if (obs_addr !== 30'h4) begin
      failures++; $display("FAIL lw_addr got=%h exp=4", obs_addr); end
    checks++; if (obs_rd !== 32'hDEAD_BEEF || obs_rd_cyc !== 1) begin
      failures++; $display("FAIL lw_data got=%h rdcyc=%0d exp DEADBEEF 1", obs_rd, obs_rd_cyc); end
    checks++; if (obs_after_busy !== 1'b0 || obs_after_rd !== 32'h0) begin
      failures++; $display("FAIL lw_no_restart got busy=%b rd=%h exp 0 0", obs_after_busy, obs_after_rd); end
  endtask

  task automatic test_lb_lbu();
    do_req(SW, 32'h10, 32'h80FF_0000, 0, 1);
    model_store(SW, 32'h10, 32'h80FF_0000);
    do_req(LB, 32'h13, 32'h0, 0, 1);
    checks++; if (obs_rd !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL lb_sext got=%h exp=FFFFFF80", obs_rd); end
    do_req(LBU, 32'h13, 32'h0, 1, 1);
    checks++; if (obs_rd !== 32'h0000_0080 || obs_stall !== 3) begin
      failures++; $display("FAIL lbu_zext got=%h stall=%0d exp 00000080 3", obs_rd, obs_stall); end
  endtask

  task automatic test_sh();
    do_req(SH, 32'h22, 32'h1234_ABCD, 3, 1);
    checks++; if (obs_byteen !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD) begin
      failures++; $display("FAIL sh_lanes got be=%b wd=%h exp 1100 ABCDABCD", obs_byteen, obs_wdata); end
    checks++; if (obs_stall !== 5 || obs_wr_cyc !== 4 || obs_rd !== 32'h0 || obs_err !== 1'b0) begin
      failures++; $display("FAIL sh_timing got stall=%0d wr=%0d rd=%h err=%b exp 5 4 0 0", obs_stall, obs_wr_cyc, obs_rd, obs_err); end
    model_store(SH, 32'h22, 32'h1234_ABCD);
    do_req(LW, 32'h20, 32'h0, 0, 1);
    checks++; if (obs_rd !== model_load(LW, 32'h20)) begin
      failures++; $display("FAIL sh_merge got=%h exp=%h", obs_rd, model_load(LW, 32'h20)); end
  endtask

  task automatic test_misaligned();
    do_req(LW, 32'h6, 32'h0, 0, 1);
    checks++; if (obs_busy0 !== 1'b0 || obs_mis0 !== 1'b1 || obs_rd_cyc !== 0 || obs_rd !== 32'h0) begin
      failures++; $display("FAIL mis_lw got busy=%b mis=%b rdcyc=%0d rd=%h exp 0 1 0 0", obs_busy0, obs_mis0, obs_rd_cyc, obs_rd); end
    checks++; if (obs_after_mis !== 1'b0 || obs_after_busy !== 1'b0) begin
      failures++; $display("FAIL mis_one_cycle got mis=%b busy=%b exp 0 0", obs_after_mis, obs_after_busy); end
    do_req(4'b1111, 32'h8, 32'h0, 0, 1);
    checks++; if (obs_busy0 !== 1'b0 || obs_mis0 !== 1'b0 || obs_rd_cyc !== 0) begin
      failures++; $display("FAIL idle_code got busy=%b mis=%b rdcyc=%0d exp 0 0 0", obs_busy0, obs_mis0, obs_rd_cyc); end
  endtask

  task automatic test_timeout();
    do_req(LW, 32'h30, 32'h0, 1000, 1);
    checks++; if (obs_rd_cyc !== T || obs_stall !== T + 1 || obs_hang) begin
      failures++; $display("FAIL to_cycles got rdcyc=%0d stall=%0d exp %0d %0d", obs_rd_cyc, obs_stall, T, T + 1); end
    checks++; if (obs_err !== 1'b1 || obs_rd !== 32'h0 || obs_done_strobe !== 1'b0) begin
      failures++; $display("FAIL to_done got err=%b rd=%h strobe=%b exp 1 0 0", obs_err, obs_rd, obs_done_strobe); end
    checks++; if (obs_after_err !== 1'b0) begin
      failures++; $display("FAIL to_err_pulse got=%b exp=0", obs_after_err); end
    // Completion on the same edge as the timeout wins.
    do_req(LW, 32'h34, 32'h0, T - 1, 1);
    checks++; if (obs_err !== 1'b0 || obs_rd !== model_load(LW, 32'h34) || obs_stall !== T + 1) begin
      failures++; $display("FAIL to_boundary got err=%b rd=%h stall=%0d exp 0 %h %0d", obs_err, obs_rd, obs_stall, model_load(LW, 32'h34), T + 1); end
  endtask

  task automatic test_reset_during_access();
    @(negedge clk);
    read_write = SW; address = 32'h40; write_data = 32'hCAFE_F00D; wait_target = 1000;
    @(negedge clk); #1;
    checks++; if (mem_write !== 1'b1 || busy_wait !== 1'b1) begin
      failures++; $display("FAIL rst_acc_pre got wr=%b busy=%b exp 1 1", mem_write, busy_wait); end
    reset = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || busy_wait !== 1'b0) begin
      failures++; $display("FAIL rst_acc_drop got wr=%b busy=%b exp 0 0", mem_write, busy_wait); end
    @(negedge clk); #1;
    checks++; if (mem_address !== 30'h0 || mem_writedata !== 32'h0 || mem_byteen !== 4'h0) begin
      failures++; $display("FAIL rst_acc_regs got ad=%h wd=%h be=%h exp 0 0 0", mem_address, mem_writedata, mem_byteen); end
    reset = 1'b1; read_write = 4'b0000;
    ref_init();
    do_req(LW, 32'h40, 32'h0, 0, 1);
    checks++; if (obs_rd !== model_load(LW, 32'h40) || obs_stall !== 2 || obs_err !== 1'b0) begin
      failures++; $display("FAIL rst_acc_after got rd=%h stall=%0d err=%b exp %h 2 0", obs_rd, obs_stall, obs_err, model_load(LW, 32'h40)); end
  endtask

  task automatic test_back_to_back();
    do_req(SB, 32'h51, 32'h0000_00A7, 0, 0);
    model_store(SB, 32'h51, 32'h0000_00A7);
    do_req(LBU, 32'h51, 32'h0, 0, 1);
    checks++; if (obs_busy0 !== 1'b1 || obs_stall !== 2 || obs_rd !== 32'h0000_00A7 || obs_hang) begin
      failures++; $display("FAIL b2b got busy0=%b stall=%0d rd=%h exp 1 2 000000A7", obs_busy0, obs_stall, obs_rd); end
  endtask

  task automatic test_random();
    logic [3:0]  codes [8];
    logic [3:0]  c, e_be;
    logic [31:0] a, d, e_rd, e_wd;
    int          wt, e_stall, e_cyc;
    bit          mis, st, to;
    codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int n = 0; n < 60; n++) begin
      c  = codes[$urandom_range(0, 7)];
      a  = 32'($urandom_range(0, 255));
      d  = $urandom;
      wt = $urandom_range(0, T + 1);
      mis = is_misaligned(c, a);
      st  = is_store(c);
      to  = (wt >= T);
      do_req(c, a, d, wt, $urandom_range(0, 1) == 1);
      e_stall = mis ? 0 : (to ? T + 1 : wt + 2);
      e_cyc   = mis ? 0 : (to ? T : wt + 1);
      e_rd    = (mis || st || to) ? 32'h0 : model_load(c, a);
      checks++; if (obs_busy0 !== !mis || obs_mis0 !== mis || obs_stall !== e_stall || obs_hang) begin
        failures++; $display("FAIL rnd_ctrl c=%b a=%h wt=%0d got busy=%b mis=%b stall=%0d exp %b %b %0d", c, a, wt, obs_busy0, obs_mis0, obs_stall, !mis, mis, e_stall); end
      checks++; if ((st ? obs_wr_cyc : obs_rd_cyc) !== e_cyc || (st ? obs_rd_cyc : obs_wr_cyc) !== 0) begin
        failures++; $display("FAIL rnd_strobe c=%b got rd=%0d wr=%0d exp %0d", c, obs_rd_cyc, obs_wr_cyc, e_cyc); end
      checks++; if (obs_rd !== e_rd || obs_err !== (to && !mis)) begin
        failures++; $display("FAIL rnd_result c=%b a=%h got rd=%h err=%b exp %h %b", c, a, obs_rd, obs_err, e_rd, to && !mis); end
      if (!mis) begin
        checks++; if (obs_addr !== a[31:2]) begin
          failures++; $display("FAIL rnd_addr got=%h exp=%h", obs_addr, a[31:2]); end
      end
      if (st && !mis) begin
        exp_lanes(c, a, d, e_be, e_wd);
        checks++; if (obs_byteen !== e_be || obs_wdata !== e_wd) begin
          failures++; $display("FAIL rnd_lanes c=%b a=%h got be=%b wd=%h exp %b %h", c, a, obs_byteen, obs_wdata, e_be, e_wd); end
        if (!to) model_store(c, a, d);
      end
    end
  endtask

  initial begin
    ref_init();
    test_reset();
    test_lw_basic();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_during_access();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/data_mem_controller.md
# data_mem_controller

Responder side of the MEM-stage memory handshake. Accepts load/store requests, generates `busy_wait` to freeze every pipeline register, and runs a word-wide access against the backing data memory. Returns aligned, sign/zero-extended load data to the MEM/WB path. Detects misaligned accesses and memory timeouts.

## Interface
- `MEM_TIMEOUT`, default 255: number of ACCESS cycles without completion before the access is aborted.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `read_write`  in  4  request code.
  - Idle: 0000.
  - Loads: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU.
  - Stores: 0100 SB, 0101 SH, 0110 SW.
  - Any other code is treated as idle.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data, right-aligned.
- `busy_wait`  out  1  stall request to all pipeline registers.
- `read_data`  out  32  extended load result; valid in the DONE cycle.
- `misaligned`  out  1  one-cycle flag; the request was dropped.
- `mem_error`  out  1  one-cycle flag; the access timed out.
- `mem_read`  out  1  backing memory read strobe.
- `mem_write`  out  1  backing memory write strobe.
- `mem_address`  out  30  word address, `address[31:2]`.
- `mem_byteen`  out  4  store byte enables.
- `mem_writedata`  out  32  store data shifted into lane position.
- `mem_readdata`  in  32  word returned by memory.
- `mem_busywait`  in  1  memory busy; low means the current strobe has completed this cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Valid aligned request: `busy_wait`=1 combinationally in the same cycle. At the clock edge, latch the code, address, shifted data and byte enables, clear the timeout counter, and go to ACCESS.
  - Misaligned request (LH/LHU/SH with `address[0]`=1; LW/SW with `address[1:0]`≠0):
    - `busy_wait` stays 0 and no memory strobe is issued.
    - `misaligned`=1 for that one cycle; `read_data` is 0.
    - Stay in IDLE.
- **ACCESS**
  - `mem_read` or `mem_write` is held at 1 from registers; `busy_wait`=1.
  - When `mem_busywait`=0 at the edge: capture the extended `mem_readdata` (loads only) into `read_data` and go to DONE.
  - Timeout counter increments each ACCESS cycle. When it reaches `MEM_TIMEOUT`: drop the strobes, set `read_data`=0, assert `mem_error` during the DONE cycle, and go to DONE.
- **DONE**
  - `busy_wait`=0 and strobes are 0.
  - `read_data` holds the result, so the pipeline advances at this edge.
  - Unconditionally return to IDLE. The request still present on the inputs in this cycle must not restart an access.
- **Lane / extension rules**, with b = `address[1:0]`:
  - LB/LBU use byte b; LH/LHU use halfword `b[1]`; LB and LH sign-extend, LBU and LHU zero-extend.
  - SB: byteen = 1<<b, data replicated to all four bytes.
  - SH: byteen = 0011 or 1100, data replicated to both halves.
  - SW: byteen = 1111.
- Store completion writes nothing to `read_data`; it is 0 in DONE.
- Reset (asynchronous, any state):
  - State goes to IDLE; the counter and all registered outputs go to 0.
  - `busy_wait`=0, `read_data`=0, `misaligned`=0, `mem_error`=0, `mem_read`=0, `mem_write`=0, `mem_byteen`=0, `mem_address`=0, `mem_writedata`=0.
  - An in-flight access is abandoned; the memory sees its strobe drop.

## Timing
- Minimum load/store latency:
  - Request at cycle 0 (IDLE, stalled).
  - Strobe at cycle 1 (ACCESS). If memory completes in cycle 1, DONE is at cycle 2.
  - This gives 2 stall cycles; each extra memory wait cycle adds one stall.
- `busy_wait` is the combinational OR of (IDLE and valid aligned request) and (state==ACCESS). It settles before the edge at which pipeline registers sample it.
- Strobe outputs and `read_data` are registered; no combinational path from `mem_readdata` to `read_data`.
- Timeout boundary: the abort happens on the edge where the counter equals `MEM_TIMEOUT`, giving exactly `MEM_TIMEOUT` ACCESS cycles. Completion on that same edge takes priority over the timeout.
- Back-to-back requests: DONE→IDLE, and a new valid request is stalled from the IDLE cycle, so there is one non-stalled cycle between accesses.

## Test plan
- LW at 0x0000_0010, memory returns 0xDEADBEEF with zero wait: `busy_wait` high cycles 0-1, `mem_address`=0x4, `read_data`=0xDEADBEEF in cycle 2.
- LB at 0x13 and LBU at 0x13, word 0x80FF_0000: `read_data`=0xFFFF_FF80 and 0x0000_0080 respectively.
- SH 0x1234ABCD at 0x22 with 3 memory wait cycles: `mem_byteen`=1100, `mem_writedata`=0xABCD_ABCD, `busy_wait` high for 5 cycles, `read_data`=0.
- LW at 0x0000_0006: `misaligned`=1 for one cycle, `busy_wait` never asserted, no `mem_read`.
- `MEM_TIMEOUT`=4, memory never completes: `mem_read` high exactly 4 cycles, then DONE with `mem_error`=1 and `read_data`=0.
- `reset` pulled low during ACCESS of an SW: `mem_write` and `busy_wait` drop immediately. After release, a fresh LW completes normally.
